// File: rtl/wb_spi_slave_pkg.sv
// Shared types and constants for the SPI-slave to Wishbone-master bridge.
package wb_spi_slave_pkg;

  // Frame FSM state encoding, also exported on the debug port.
  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_CMD   = 3'd1;
  localparam state_t ST_ADDR  = 3'd2;
  localparam state_t ST_WDATA = 3'd3;
  localparam state_t ST_RPAD  = 3'd4;
  localparam state_t ST_RDATA = 3'd5;
  localparam state_t ST_WAIT  = 3'd6;

  // Host command opcodes.
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_READ  = 8'h0B;

  // Phase lengths in SCK bits.
  localparam logic [5:0] LEN_CMD  = 6'd8;
  localparam logic [5:0] LEN_ADDR = 6'd32;
  localparam logic [5:0] LEN_PAD  = 6'd8;
  localparam logic [5:0] LEN_DATA = 6'd32;

  // Word returned to the host when no valid read data is available.
  localparam logic [31:0] RD_FILL = 32'hFFFF_FFFF;

  // True when the bit being sampled is the last one of a phase.
  function automatic logic phase_done(input logic [5:0] cnt, input logic [5:0] len);
    return cnt == (len - 6'd1);
  endfunction

endpackage

// File: rtl/wb_spi_slave_if.sv
// Wishbone classic bus bundle between the bridge (master) and the interconnect.
//
// Handshake: the master raises cyc and stb together with adr/dat/we/sel and
// holds all of them stable until it samples ack high on a rising clk edge
// (or gives up on timeout); it drops cyc/stb on the following clk. ack is
// only meaningful while cyc is high; dat_i is captured in the ack cycle.
interface wb_spi_slave_if;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_ack_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
    output wb_dat_i, wb_ack_i
  );
endinterface

// File: rtl/spi_pin_sync.sv
// Two-flop synchronizers for the SPI pins plus edge pulses derived from the
// synchronized history. Pulses are one clk wide and aligned with o_mosi.
module spi_pin_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sck,
  input  logic i_cs_n,
  input  logic i_mosi,
  output logic o_sck_rise,
  output logic o_sck_fall,
  output logic o_cs_fall,
  output logic o_cs_rise,
  output logic o_mosi
);

  // [0] and [1] form the synchronizer, [2] is the history bit for edges.
  logic [2:0] r_sck;
  logic [2:0] r_cs_n;
  logic [1:0] r_mosi;

  // Shift pin samples through the synchronizer chains; cs_n idles high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sck  <= 3'b000;
      r_cs_n <= 3'b111;
      r_mosi <= 2'b00;
    end else begin
      r_sck  <= {r_sck[1:0], i_sck};
      r_cs_n <= {r_cs_n[1:0], i_cs_n};
      r_mosi <= {r_mosi[0], i_mosi};
    end
  end

  assign o_sck_rise = r_sck[1] & ~r_sck[2];
  assign o_sck_fall = ~r_sck[1] & r_sck[2];
  assign o_cs_fall  = ~r_cs_n[1] & r_cs_n[2];
  assign o_cs_rise  = r_cs_n[1] & ~r_cs_n[2];
  assign o_mosi     = r_mosi[1];

endmodule

// File: rtl/wb_spi_slave.sv
// SPI mode-0 slave that decodes host read/write frames and replays each as a
// single Wishbone classic master cycle. Everything runs on clk; SCK is
// oversampled through spi_pin_sync.
module wb_spi_slave
  import wb_spi_slave_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           spi_sck,
  input  logic           spi_cs_n,
  input  logic           spi_mosi,
  output logic           spi_miso,
  output logic           busy,
  output logic           err,
  output state_t         o_dbg_state,
  wb_spi_slave_if.master wb
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  // Synchronized pin events.
  logic w_sck_rise;
  logic w_sck_fall;
  logic w_cs_fall;
  logic w_cs_rise;
  logic w_mosi;

  // Frame FSM and shift path.
  state_t      r_state;
  logic [5:0]  r_bit_cnt;
  logic [31:0] r_sh_in;
  logic [31:0] r_sh_out;
  logic [7:0]  r_cmd;
  logic [31:0] r_adr;
  logic [31:0] r_wdat;
  logic        r_issue_wr;
  logic        r_issue_rd;
  logic        r_miso;

  // Wishbone master side.
  logic        r_cyc;
  logic        r_we;
  logic [31:0] r_adr_o;
  logic [31:0] r_dat_o;
  logic [7:0]  r_to_cnt;
  logic [31:0] r_hold;
  logic        r_rd_valid;
  logic        r_err;

  // Decoded events.
  logic [31:0] w_sh_next;
  logic [5:0]  w_phase_len;
  logic        w_in_frame;
  logic        w_bit_ev;
  logic        w_last;
  logic        w_cmd_ok;
  logic        w_bad_cmd;
  logic        w_overrun;
  logic        w_late;
  logic        w_timeout;

  spi_pin_sync u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_sck      (spi_sck),
    .i_cs_n     (spi_cs_n),
    .i_mosi     (spi_mosi),
    .o_sck_rise (w_sck_rise),
    .o_sck_fall (w_sck_fall),
    .o_cs_fall  (w_cs_fall),
    .o_cs_rise  (w_cs_rise),
    .o_mosi     (w_mosi)
  );

  // Length of the phase the FSM is currently counting.
  always_comb begin
    w_phase_len = LEN_DATA;
    case (r_state)
      ST_CMD:   w_phase_len = LEN_CMD;
      ST_ADDR:  w_phase_len = LEN_ADDR;
      ST_WDATA: w_phase_len = LEN_DATA;
      ST_RPAD:  w_phase_len = LEN_PAD;
      ST_RDATA: w_phase_len = LEN_DATA;
      default:  w_phase_len = LEN_DATA;
    endcase
  end

  assign w_sh_next  = {r_sh_in[30:0], w_mosi};
  assign w_in_frame = (r_state == ST_CMD) || (r_state == ST_ADDR) ||
                      (r_state == ST_WDATA) || (r_state == ST_RPAD) ||
                      (r_state == ST_RDATA);
  // A frame bit counts only when cs_n is not changing in the same clk.
  assign w_bit_ev   = w_sck_rise & ~w_cs_rise & ~w_cs_fall & w_in_frame;
  assign w_last     = phase_done(r_bit_cnt, w_phase_len);
  assign w_cmd_ok   = (w_sh_next[7:0] == CMD_WRITE) || (w_sh_next[7:0] == CMD_READ);

  assign w_bad_cmd  = w_bit_ev & (r_state == ST_CMD) & w_last & ~w_cmd_ok;
  assign w_overrun  = w_cs_fall & ~w_cs_rise & r_cyc;
  assign w_late     = w_bit_ev & (r_state == ST_RPAD) & w_last & ~r_rd_valid;
  assign w_timeout  = r_cyc & ~wb.wb_ack_i & (r_to_cnt == TO_LAST);

  // Frame FSM: phase sequencing, bit counting, shift-in and shift-out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_bit_cnt  <= '0;
      r_sh_in    <= '0;
      r_sh_out   <= '0;
      r_cmd      <= '0;
      r_adr      <= '0;
      r_wdat     <= '0;
      r_issue_wr <= 1'b0;
      r_issue_rd <= 1'b0;
    end else begin
      r_issue_wr <= 1'b0;
      r_issue_rd <= 1'b0;
      if (w_cs_rise) begin
        // Any state: frame ends or is aborted; issued cycles run on.
        r_state   <= ST_IDLE;
        r_bit_cnt <= '0;
        r_sh_out  <= '0;
      end else if (w_cs_fall) begin
        r_state   <= r_cyc ? ST_WAIT : ST_CMD;
        r_bit_cnt <= '0;
      end else if (w_bit_ev) begin
        r_sh_in <= w_sh_next;
        if (w_last) begin
          r_bit_cnt <= '0;
          case (r_state)
            ST_CMD: begin
              r_cmd   <= w_sh_next[7:0];
              r_state <= w_cmd_ok ? ST_ADDR : ST_WAIT;
            end
            ST_ADDR: begin
              r_adr <= w_sh_next;
              if (r_cmd == CMD_READ) begin
                r_state    <= ST_RPAD;
                r_issue_rd <= 1'b1;
              end else begin
                r_state <= ST_WDATA;
              end
            end
            ST_WDATA: begin
              r_wdat     <= w_sh_next;
              r_issue_wr <= 1'b1;
              r_state    <= ST_WAIT;
            end
            ST_RPAD: begin
              r_sh_out <= r_rd_valid ? r_hold : RD_FILL;
              r_state  <= ST_RDATA;
            end
            default: r_state <= ST_WAIT;
          endcase
        end else begin
          r_bit_cnt <= r_bit_cnt + 6'd1;
        end
      end else if (w_sck_fall && (r_state == ST_RDATA)) begin
        r_sh_out <= {r_sh_out[30:0], 1'b0};
      end
    end
  end

  // MISO presents the next read bit on each falling SCK; 0 outside RDATA.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_miso <= 1'b0;
    end else if ((r_state == ST_RDATA) && w_sck_fall && !w_cs_rise) begin
      r_miso <= r_sh_out[31];
    end else if (r_state != ST_RDATA) begin
      r_miso <= 1'b0;
    end
  end

  // Wishbone master: launch on issue, finish on ack or timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cyc      <= 1'b0;
      r_we       <= 1'b0;
      r_adr_o    <= '0;
      r_dat_o    <= '0;
      r_to_cnt   <= '0;
      r_hold     <= '0;
      r_rd_valid <= 1'b0;
    end else if (r_cyc) begin
      if (wb.wb_ack_i) begin
        r_cyc <= 1'b0;
        r_we  <= 1'b0;
        if (!r_we) begin
          r_hold     <= wb.wb_dat_i;
          r_rd_valid <= 1'b1;
        end
      end else if (w_timeout) begin
        r_cyc <= 1'b0;
        r_we  <= 1'b0;
        if (!r_we) begin
          r_hold     <= RD_FILL;
          r_rd_valid <= 1'b1;
        end
      end else begin
        r_to_cnt <= r_to_cnt + 8'd1;
      end
    end else if (r_issue_wr || r_issue_rd) begin
      r_cyc    <= 1'b1;
      r_we     <= r_issue_wr;
      r_adr_o  <= r_adr;
      r_dat_o  <= r_issue_wr ? r_wdat : 32'h0;
      r_to_cnt <= '0;
      if (r_issue_rd) r_rd_valid <= 1'b0;
    end
  end

  // Error pulse: bad command, overrun, late read data or bus timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_bad_cmd | w_overrun | w_late | w_timeout;
    end
  end

  assign wb.wb_cyc_o = r_cyc;
  assign wb.wb_stb_o = r_cyc;
  assign wb.wb_we_o  = r_we;
  assign wb.wb_sel_o = r_cyc ? 4'hF : 4'h0;
  assign wb.wb_adr_o = r_adr_o;
  assign wb.wb_dat_o = r_dat_o;

  assign spi_miso    = r_miso;
  assign busy        = r_cyc;
  assign err         = r_err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_wb_spi_slave.sv
// Bench for wb_spi_slave: an SPI host driver, a Wishbone responder model and
// scoreboards for bus transactions and read words returned on MISO.
module tb_wb_spi_slave;
  import wb_spi_slave_pkg::*;

  localparam int HALF = 8;   // SCK half period in clk cycles
  localparam int TO   = 16;

  logic   clk;
  logic   rst_n;
  logic   spi_sck;
  logic   spi_cs_n;
  logic   spi_mosi;
  logic   spi_miso;
  logic   busy;
  logic   err;
  state_t dbg_state;

  wb_spi_slave_if wb_bus ();

  wb_spi_slave #(.TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .spi_sck     (spi_sck),
    .spi_cs_n    (spi_cs_n),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .busy        (busy),
    .err         (err),
    .o_dbg_state (dbg_state),
    .wb          (wb_bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  int n_pass   = 0;
  int n_checks = 0;

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Scoreboards: {we, sel, adr, dat (write only)} and read words.
  logic [68:0] exp_q[$];
  logic [31:0] exp_rd_q[$];

  // ---------------- Wishbone responder / monitor ----------------
  int          ack_delay = 1;      // -1: never acknowledge
  logic [31:0] rd_data   = 32'h0;
  int          wb_cycles = 0;
  int          err_cnt   = 0;
  int          last_cyc_len = 0;
  logic        busy_bad  = 1'b0;

  initial begin : responder
    logic        in_cyc;
    logic        unstable;
    logic [69:0] latched;
    logic [69:0] now_v;
    logic [68:0] exp_t;
    int          cnt;
    int          cyc_len;
    in_cyc   = 1'b0;
    unstable = 1'b0;
    latched  = '0;
    cnt      = 0;
    cyc_len  = 0;
    wb_bus.wb_ack_i = 1'b0;
    wb_bus.wb_dat_i = 32'h0;
    forever begin
      @(negedge clk);
      now_v = {wb_bus.wb_stb_o, wb_bus.wb_we_o, wb_bus.wb_sel_o, wb_bus.wb_adr_o,
               wb_bus.wb_we_o ? wb_bus.wb_dat_o : 32'h0};
      if (busy !== wb_bus.wb_cyc_o) busy_bad = 1'b1;
      if (err === 1'b1) err_cnt++;
      if (wb_bus.wb_cyc_o === 1'b1) begin
        if (!in_cyc) begin
          in_cyc   = 1'b1;
          unstable = 1'b0;
          latched  = now_v;
          cnt      = 0;
          cyc_len  = 0;
          wb_cycles++;
          chk("wb_expected", 72'(exp_q.size() != 0), 72'd1);
          if (exp_q.size() != 0) begin
            exp_t = exp_q.pop_front();
            chk("wb_txn", 72'(now_v[68:0]), 72'(exp_t));
          end
        end
        if (now_v !== latched || wb_bus.wb_stb_o !== 1'b1) unstable = 1'b1;
        cyc_len++;
        cnt++;
        if (cnt == ack_delay) begin
          wb_bus.wb_ack_i = 1'b1;
          wb_bus.wb_dat_i = rd_data;
        end
      end else begin
        if (in_cyc) begin
          chk("wb_stable", 72'(unstable), 72'd0);
          last_cyc_len = cyc_len;
          in_cyc = 1'b0;
        end
        wb_bus.wb_ack_i = 1'b0;
        wb_bus.wb_dat_i = 32'h0;
      end
    end
  end

  // ---------------- host driver tasks ----------------
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [31:0] tx, input int n, output logic [31:0] rx);
    rx = 32'h0;
    for (int i = n - 1; i >= 0; i--) begin
      spi_mosi = tx[i];
      wait_clk(HALF);
      spi_sck = 1'b1;
      rx = {rx[30:0], spi_miso};
      wait_clk(HALF);
      spi_sck = 1'b0;
    end
  endtask

  task automatic do_write(input logic [31:0] adr, input logic [31:0] dat);
    logic [31:0] rx;
    exp_q.push_back({1'b1, 4'hF, adr, dat});
    spi_cs_n = 1'b0;
    wait_clk(HALF);
    spi_bits(32'h02, 8, rx);
    spi_bits(adr, 32, rx);
    spi_bits(dat, 32, rx);
    wait_clk(HALF);
    spi_cs_n = 1'b1;
    wait_clk(40);
  endtask

  task automatic do_read(input string tag, input logic [31:0] adr);
    logic [31:0] rx;
    logic [31:0] exp_w;
    exp_q.push_back({1'b0, 4'hF, adr, 32'h0});
    spi_cs_n = 1'b0;
    wait_clk(HALF);
    spi_bits(32'h0B, 8, rx);
    spi_bits(adr, 32, rx);
    spi_bits(32'h0, 8, rx);
    spi_bits(32'h0, 32, rx);
    wait_clk(HALF);
    spi_cs_n = 1'b1;
    exp_w = exp_rd_q.pop_front();
    chk(tag, 72'(rx), 72'(exp_w));
    wait_clk(40);
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    int          e0;
    int          c0;
    logic [31:0] rx;
    logic [31:0] a;
    logic [31:0] d;
    rst_n    = 1'b0;
    spi_sck  = 1'b0;
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    wait_clk(3);
    chk("rst_wb", {wb_bus.wb_adr_o, wb_bus.wb_dat_o, wb_bus.wb_sel_o,
                   wb_bus.wb_we_o, wb_bus.wb_cyc_o, wb_bus.wb_stb_o}, 72'd0);
    chk("rst_misc", 72'({spi_miso, busy, err}), 72'd0);
    chk("rst_state", 72'(dbg_state), 72'(ST_IDLE));
    rst_n = 1'b1;
    wait_clk(5);

    // Basic write
    ack_delay = 2;
    e0 = err_cnt; c0 = wb_cycles;
    do_write(32'h4000_0000, 32'h0000_00A5);
    chk("wr_cycles", 72'(wb_cycles - c0), 72'd1);
    chk("wr_err", 72'(err_cnt - e0), 72'd0);
    chk("wr_state", 72'(dbg_state), 72'(ST_IDLE));

    // Basic read
    ack_delay = 3; rd_data = 32'hCAFE_F00D;
    exp_rd_q.push_back(32'hCAFE_F00D);
    e0 = err_cnt;
    do_read("rd_data", 32'h0000_0010);
    chk("rd_err", 72'(err_cnt - e0), 72'd0);

    // Read timeout
    ack_delay = -1;
    exp_rd_q.push_back(32'hFFFF_FFFF);
    e0 = err_cnt;
    do_read("to_data", 32'h0900_0000);
    chk("to_len", 72'(last_cyc_len), 72'(TO));
    chk("to_err", 72'(err_cnt - e0), 72'd1);

    // Abort after 20 address bits, then a full write
    ack_delay = 4;
    e0 = err_cnt; c0 = wb_cycles;
    spi_cs_n = 1'b0;
    wait_clk(HALF);
    spi_bits(32'h02, 8, rx);
    spi_bits(32'h000A_BCDE, 20, rx);
    wait_clk(HALF);
    spi_cs_n = 1'b1;
    wait_clk(40);
    chk("abort_state", 72'(dbg_state), 72'(ST_IDLE));
    chk("abort_cycles", 72'(wb_cycles - c0), 72'd0);
    do_write(32'h2000_0004, 32'h1234_5678);
    chk("abort_next_cycles", 72'(wb_cycles - c0), 72'd1);
    chk("abort_err", 72'(err_cnt - e0), 72'd0);

    // Unknown command
    e0 = err_cnt; c0 = wb_cycles;
    spi_cs_n = 1'b0;
    wait_clk(HALF);
    spi_bits(32'h3F, 8, rx);
    spi_bits($urandom, 32, rx);
    chk("badcmd_miso", 72'(rx), 72'd0);
    chk("badcmd_state", 72'(dbg_state), 72'(ST_WAIT));
    wait_clk(HALF);
    spi_cs_n = 1'b1;
    wait_clk(40);
    chk("badcmd_err", 72'(err_cnt - e0), 72'd1);
    chk("badcmd_cycles", 72'(wb_cycles - c0), 72'd0);

    // Aborted read followed by a frame while the bus cycle is outstanding
    ack_delay = -1;
    e0 = err_cnt; c0 = wb_cycles;
    exp_q.push_back({1'b0, 4'hF, 32'h0600_0000, 32'h0});
    spi_cs_n = 1'b0;
    wait_clk(HALF);
    spi_bits(32'h0B, 8, rx);
    spi_bits(32'h0600_0000, 32, rx);
    spi_cs_n = 1'b1;
    wait_clk(2);
    spi_cs_n = 1'b0;
    wait_clk(6);
    chk("ovr_state", 72'(dbg_state), 72'(ST_WAIT));
    spi_bits(32'hA5, 8, rx);
    chk("ovr_miso", 72'(rx), 72'd0);
    spi_cs_n = 1'b1;
    wait_clk(40);
    chk("ovr_err", 72'(err_cnt - e0), 72'd2);
    chk("ovr_cycles", 72'(wb_cycles - c0), 72'd1);

    // Randomized writes and reads
    for (int k = 0; k < 2; k++) begin
      ack_delay = $urandom_range(1, 12);
      a = $urandom; d = $urandom;
      do_write(a, d);
      ack_delay = $urandom_range(1, 12);
      rd_data = $urandom;
      exp_rd_q.push_back(rd_data);
      do_read("rand_rd", $urandom);
    end

    // Reset while a write cycle is outstanding
    ack_delay = -1;
    exp_q.push_back({1'b1, 4'hF, 32'h0300_0008, 32'h0BAD_BEEF});
    spi_cs_n = 1'b0;
    wait_clk(HALF);
    spi_bits(32'h02, 8, rx);
    spi_bits(32'h0300_0008, 32, rx);
    spi_bits(32'h0BAD_BEEF, 32, rx);
    for (int i = 0; i < 30 && wb_bus.wb_cyc_o !== 1'b1; i++) wait_clk(1);
    chk("rst2_cyc_up", 72'(wb_bus.wb_cyc_o), 72'd1);
    rst_n = 1'b0;
    #1;
    chk("rst2_wb", {wb_bus.wb_adr_o, wb_bus.wb_dat_o, wb_bus.wb_sel_o,
                    wb_bus.wb_we_o, wb_bus.wb_cyc_o, wb_bus.wb_stb_o}, 72'd0);
    chk("rst2_misc", 72'({spi_miso, busy, err}), 72'd0);
    chk("rst2_state", 72'(dbg_state), 72'(ST_IDLE));
    spi_cs_n = 1'b1;
    spi_sck  = 1'b0;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(10);
    ack_delay = 2; rd_data = 32'h5A5A_C3C3;
    exp_rd_q.push_back(32'h5A5A_C3C3);
    e0 = err_cnt;
    do_read("rst2_rd", 32'h0000_0020);
    chk("rst2_rd_err", 72'(err_cnt - e0), 72'd0);

    chk("wb_q_drained", 72'(exp_q.size()), 72'd0);
    chk("busy_mirror", 72'(busy_bad), 72'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
